muldiv_unit: RTL

- Iterative multiply/divide sequencer beside the execute stage. Executes MULT/MULTU/DIV/DIVU over multiple cycles, owns the HI/LO register pair and handles MTHI/MTLO.
- Raises a stall toward the hazard logic while an operation is in flight.
- Single-cycle ALU ops continue to use the existing execute datapath. This block arbitrates access to HI/LO between the multi-cycle engine and the direct moves.

---
 rtl/muldiv_unit.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer that owns HI/LO and also services MTHI/MTLO.
// Define MULDIV_EARLY_OUT_EN to end multiplies once the remaining multiplier bits are zero.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_e_i,
    input  logic [2:0]       op_e_i,
    input  logic [WIDTH-1:0] src_a_e_i,
    input  logic [WIDTH-1:0] src_b_e_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    localparam logic [2:0]       OP_MTHI = 3'd4;
    localparam logic [2:0]       OP_MTLO = 3'd5;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t               r_state;
    state_t               w_next;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_isDiv;
    logic                 r_resNeg;
    logic                 r_remNeg;
    logic [2*WIDTH-1:0]   r_prod;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [WIDTH-1:0]     r_rem;
    logic [WIDTH-1:0]     r_quot;
    logic [WIDTH-1:0]     r_divisor;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;

    logic                 w_isMulDiv;
    logic                 w_signedOp;
    logic                 w_accept;
    logic                 w_resNeg;
    logic                 w_remNeg;
    logic                 w_lastIter;
    logic [WIDTH-1:0]     w_absA;
    logic [WIDTH-1:0]     w_absB;
    logic [2*WIDTH-1:0]   w_mulAcc;
    logic [2*WIDTH-1:0]   w_mulFinal;
    logic [WIDTH:0]       w_divShift;
    logic [WIDTH-1:0]     w_divSub;
    logic                 w_divOk;

    assign w_isMulDiv = start_e_i && !op_e_i[2];
    assign w_signedOp = !op_e_i[0];
    assign w_accept   = (r_state == S_IDLE) && w_isMulDiv && !flush_i;
    assign w_absA     = (w_signedOp && src_a_e_i[WIDTH-1]) ? -src_a_e_i : src_a_e_i;
    assign w_absB     = (w_signedOp && src_b_e_i[WIDTH-1]) ? -src_b_e_i : src_b_e_i;
    // A zero divisor leaves the quotient as all ones, so its sign fix is suppressed.
    assign w_resNeg   = w_signedOp && (src_a_e_i[WIDTH-1] ^ src_b_e_i[WIDTH-1])
                        && !(op_e_i[1] && (src_b_e_i == '0));
    assign w_remNeg   = w_signedOp && src_a_e_i[WIDTH-1];

    assign w_mulAcc   = r_prod + (r_mplier[0] ? r_mcand : '0);
    assign w_mulFinal = r_resNeg ? -r_prod : r_prod;

    // Restoring step: the shifted partial remainder is one bit wider than the divisor.
    assign w_divShift = {r_rem, r_quot[WIDTH-1]};
    assign w_divOk    = (w_divShift >= {1'b0, r_divisor});
    assign w_divSub   = WIDTH'(w_divShift - {1'b0, r_divisor});

`ifdef MULDIV_EARLY_OUT_EN
    assign w_lastIter = (r_cnt == CNT_ONE) || (!r_isDiv && ((r_mplier >> 1) == '0));
`else
    assign w_lastIter = (r_cnt == CNT_ONE);
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        stall_o = 1'b0;
        done_o  = 1'b0;
        case (r_state)
            S_IDLE: begin
                stall_o = w_isMulDiv;
                if (w_accept) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                stall_o = 1'b1;
                if (w_lastIter) begin
                    w_next = S_FIX;
                end
            end
            S_FIX: begin
                stall_o = 1'b1;
                done_o  = !flush_i;
                w_next  = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (flush_i) begin
            w_next = S_IDLE;
        end
        if (!rst_i) begin
            stall_o = 1'b0;
        end
    end

    // Operand capture, one iteration per RUN cycle, and the HI/LO write ports.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt     <= '0;
            r_isDiv   <= 1'b0;
            r_resNeg  <= 1'b0;
            r_remNeg  <= 1'b0;
            r_prod    <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_rem     <= '0;
            r_quot    <= '0;
            r_divisor <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt     <= CNT_W'(WIDTH);
                        r_isDiv   <= op_e_i[1];
                        r_resNeg  <= w_resNeg;
                        r_remNeg  <= w_remNeg;
                        r_prod    <= '0;
                        r_mcand   <= {{WIDTH{1'b0}}, w_absA};
                        r_mplier  <= w_absB;
                        r_rem     <= '0;
                        r_quot    <= w_absA;
                        r_divisor <= w_absB;
                    end else if (start_e_i && !flush_i && (op_e_i == OP_MTHI)) begin
                        r_hi <= src_a_e_i;
                    end else if (start_e_i && !flush_i && (op_e_i == OP_MTLO)) begin
                        r_lo <= src_a_e_i;
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt - CNT_ONE;
                    if (r_isDiv) begin
                        r_rem  <= w_divOk ? w_divSub : w_divShift[WIDTH-1:0];
                        r_quot <= {r_quot[WIDTH-2:0], w_divOk};
                    end else begin
                        r_prod   <= w_mulAcc;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                    end
                end
                S_FIX: begin
                    if (!flush_i) begin
                        if (r_isDiv) begin
                            r_hi <= r_remNeg ? -r_rem : r_rem;
                            r_lo <= r_resNeg ? -r_quot : r_quot;
                        end else begin
                            r_hi <= w_mulFinal[2*WIDTH-1:WIDTH];
                            r_lo <= w_mulFinal[WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi_o = r_hi;
    assign lo_o = r_lo;

endmodule
